// File: rtl/axis_result_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_result_streamer_if
//  Description : AXI4-Stream master-side bundle (TVALID/TDATA/TLAST/TREADY)
//                used by the result streamer output stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_result_streamer_if #(
    parameter int AXIS_WIDTH = 32
);
    logic                  tvalid;
    logic [AXIS_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tready;

    // Source side of the stream
    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    // Sink side of the stream
    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/axis_result_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_result_streamer
//  Description : Reads NUM_WORDS entries from a synchronous-read result RAM
//                on START and emits them as one AXI4-Stream packet. Entries
//                are zero-extended to AXIS_WIDTH, the last beat carries
//                TLAST, and a 2-entry output FIFO absorbs TREADY backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_result_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int AXIS_WIDTH = 32,
    parameter int NUM_WORDS  = 2,
    parameter int ADDR_WIDTH = 1
) (
    input  wire                   ACLK,
    input  wire                   ARESETN,
    input  wire                   i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_ram_rden,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    input  wire  [DATA_WIDTH-1:0] i_ram_rdata,
    axis_result_streamer_if.master m_axis
);

    // The read pointer must be able to hold NUM_WORDS itself (the "all reads
    // issued" value); ADDR_WIDTH+1 bits always suffice for that.
    localparam int                    PTR_W       = ADDR_WIDTH + 1;
    localparam logic [PTR_W-1:0]      c_NUM_WORDS = PTR_W'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_rd_ptr;

    // Read pipeline: o_ram_rden is the request cycle, r_cap marks the cycle
    // in which RAM data is valid and gets pushed at the next edge.
    logic                  r_cap;
    logic                  r_cap_last;

    // Two-entry shift FIFO; slot 0 is always the head presented on the bus.
    logic                  r_v0;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d0;
    logic [DATA_WIDTH-1:0] r_d1;
    logic                  r_l0;
    logic                  r_l1;

    logic                  w_pop;
    logic                  w_push;
    logic [2:0]            w_occ;
    logic                  w_issue;

    assign w_pop  = r_v0 & m_axis.tready;
    assign w_push = r_cap;

    // Slots committed after this edge if no new read is issued: stored
    // entries plus both in-flight reads, less the beat leaving now.
    assign w_occ   = 3'(r_v0) + 3'(r_v1) + 3'(r_cap) + 3'(o_ram_rden) - 3'(w_pop);
    assign w_issue = (r_state == S_STREAM) && (r_rd_ptr < c_NUM_WORDS) && (w_occ < 3'd2);

    assign m_axis.tvalid = r_v0;
    assign m_axis.tdata  = AXIS_WIDTH'(r_d0);
    assign m_axis.tlast  = r_l0;

    // Packet control FSM with registered status and RAM read requests
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state    <= S_IDLE;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_ram_rden <= 1'b0;
            o_ram_addr <= '0;
            r_rd_ptr   <= '0;
        end else begin
            o_ram_rden <= 1'b0;
            o_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // FIFO is empty here, so the first read goes out at once
                        r_state    <= S_STREAM;
                        o_busy     <= 1'b1;
                        o_ram_rden <= 1'b1;
                        o_ram_addr <= '0;
                        r_rd_ptr   <= PTR_W'(1);
                    end
                end
                S_STREAM: begin
                    if (w_issue) begin
                        o_ram_rden <= 1'b1;
                        o_ram_addr <= r_rd_ptr[ADDR_WIDTH-1:0];
                        r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
                    end
                    if (w_pop && r_l0) begin
                        r_state <= S_DONE;
                        o_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Track which cycle carries valid RAM data and whether it is the last entry
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cap      <= 1'b0;
            r_cap_last <= 1'b0;
        end else begin
            r_cap      <= o_ram_rden;
            r_cap_last <= o_ram_rden && (o_ram_addr == c_LAST_ADDR);
        end
    end

    // Output FIFO: push captured RAM data, pop on handshake, shift toward slot 0
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
            r_l0 <= 1'b0;
            r_l1 <= 1'b0;
        end else if (w_pop) begin
            if (r_v1) begin
                r_d0 <= r_d1;
                r_l0 <= r_l1;
                r_v1 <= w_push;
                if (w_push) begin
                    r_d1 <= i_ram_rdata;
                    r_l1 <= r_cap_last;
                end
            end else begin
                r_v0 <= w_push;
                if (w_push) begin
                    r_d0 <= i_ram_rdata;
                    r_l0 <= r_cap_last;
                end
            end
        end else if (w_push) begin
            if (!r_v0) begin
                r_v0 <= 1'b1;
                r_d0 <= i_ram_rdata;
                r_l0 <= r_cap_last;
            end else begin
                r_v1 <= 1'b1;
                r_d1 <= i_ram_rdata;
                r_l1 <= r_cap_last;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_result_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_axis_result_streamer
//  Description : Bench for axis_result_streamer with three instances
//                (NUM_WORDS = 2, 8, 1) against a packet-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_result_streamer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       start0, start1, start2;
    logic       busy0, busy1, busy2;
    logic       done0, done1, done2;
    logic       rden0, rden1, rden2;
    logic [0:0] addr0, addr2;
    logic [2:0] addr1;
    logic [7:0] rdata0, rdata1, rdata2;
    logic [7:0] mem0 [2];
    logic [7:0] mem1 [8];
    logic [7:0] mem2 [1];

    axis_result_streamer_if #(.AXIS_WIDTH(32)) ax0 ();
    axis_result_streamer_if #(.AXIS_WIDTH(32)) ax1 ();
    axis_result_streamer_if #(.AXIS_WIDTH(32)) ax2 ();

    axis_result_streamer #(.DATA_WIDTH(8), .AXIS_WIDTH(32), .NUM_WORDS(2), .ADDR_WIDTH(1)) u_dut0 (
        .ACLK(clk), .ARESETN(rst_n), .i_start(start0), .o_busy(busy0), .o_done(done0),
        .o_ram_rden(rden0), .o_ram_addr(addr0), .i_ram_rdata(rdata0), .m_axis(ax0));
    axis_result_streamer #(.DATA_WIDTH(8), .AXIS_WIDTH(32), .NUM_WORDS(8), .ADDR_WIDTH(3)) u_dut1 (
        .ACLK(clk), .ARESETN(rst_n), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_ram_rden(rden1), .o_ram_addr(addr1), .i_ram_rdata(rdata1), .m_axis(ax1));
    axis_result_streamer #(.DATA_WIDTH(8), .AXIS_WIDTH(32), .NUM_WORDS(1), .ADDR_WIDTH(1)) u_dut2 (
        .ACLK(clk), .ARESETN(rst_n), .i_start(start2), .o_busy(busy2), .o_done(done2),
        .o_ram_rden(rden2), .o_ram_addr(addr2), .i_ram_rdata(rdata2), .m_axis(ax2));

    // Synchronous-read RAMs, one per instance
    always @(posedge clk) if (rden0) rdata0 <= mem0[addr0];
    always @(posedge clk) if (rden1) rdata1 <= mem1[addr1];
    always @(posedge clk) if (rden2) rdata2 <= (addr2 == 1'b0) ? mem2[0] : 8'hEE;

    int n_chk = 0;
    int n_fail = 0;
    int neg_no = 0;

    // sampled DUT outputs
    logic        o_valid [3], o_last [3], o_busy [3], o_done [3], o_rden [3], o_ready [3], o_start [3];
    logic [31:0] o_data  [3];
    int          o_addr  [3];

    // packet-level model state
    int m_busy [3], m_beat [3], m_done_due [3], m_next_addr [3], m_since [3], prev_stall [3];

    // per-packet observation log
    int          lg_n [3], lg_done_n [3], lg_done_neg [3], lg_busy_n [3], lg_max_addr [3], lg_start_neg [3];
    logic [31:0] lg_data [3][8];
    logic        lg_last [3][8];
    int          lg_neg  [3][8];

    function automatic int nw(input int k);
        return (k == 0) ? 2 : (k == 1) ? 8 : 1;
    endfunction

    // Expected TDATA for beat i: RAM entry zero-extended to 32 bits
    function automatic logic [31:0] memval(input int k, input int i);
        logic [7:0] v;
        v = 8'h00;
        case (k)
            0:       v = mem0[i];
            1:       v = mem1[i];
            default: v = mem2[0];
        endcase
        return {24'h000000, v};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        o_valid[0] = ax0.tvalid; o_data[0] = ax0.tdata; o_last[0] = ax0.tlast; o_ready[0] = ax0.tready;
        o_valid[1] = ax1.tvalid; o_data[1] = ax1.tdata; o_last[1] = ax1.tlast; o_ready[1] = ax1.tready;
        o_valid[2] = ax2.tvalid; o_data[2] = ax2.tdata; o_last[2] = ax2.tlast; o_ready[2] = ax2.tready;
        o_busy[0] = busy0; o_done[0] = done0; o_rden[0] = rden0; o_addr[0] = int'(addr0); o_start[0] = start0;
        o_busy[1] = busy1; o_done[1] = done1; o_rden[1] = rden1; o_addr[1] = int'(addr1); o_start[1] = start1;
        o_busy[2] = busy2; o_done[2] = done2; o_rden[2] = rden2; o_addr[2] = int'(addr2); o_start[2] = start2;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_beat[k] = 0; m_done_due[k] = 0;
            m_next_addr[k] = 0; m_since[k] = -1; prev_stall[k] = 0;
        end
    endtask

    task automatic clear_log(input int k);
        lg_n[k] = 0; lg_done_n[k] = 0; lg_done_neg[k] = 0;
        lg_busy_n[k] = 0; lg_max_addr[k] = 0; lg_start_neg[k] = 0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic cyc();
        logic hs [3];
        logic acc [3];
        @(negedge clk);
        neg_no++;
        sample();
        for (int k = 0; k < 3; k++) begin
            hs[k]  = o_valid[k] & o_ready[k];
            acc[k] = o_start[k] & (m_busy[k] == 0);
            check($sformatf("d%0d_done", k), 32'(o_done[k]), 32'(m_done_due[k]));
            check($sformatf("d%0d_busy", k), 32'(o_busy[k]), 32'(m_busy[k]));
            if (m_busy[k] != 0 && m_since[k] == 0)
                check($sformatf("d%0d_first_rden", k), 32'(o_rden[k]), 32'd1);
            if (m_busy[k] != 0 && m_since[k] >= 0 && m_since[k] < 2)
                check($sformatf("d%0d_early_valid", k), 32'(o_valid[k]), 32'd0);
            if (m_busy[k] != 0 && m_since[k] == 2)
                check($sformatf("d%0d_valid_latency", k), 32'(o_valid[k]), 32'd1);
            if (prev_stall[k] != 0)
                check($sformatf("d%0d_valid_held", k), 32'(o_valid[k]), 32'd1);
            if (o_valid[k]) begin
                if (m_busy[k] != 0 && m_beat[k] < nw(k)) begin
                    check($sformatf("d%0d_tdata", k), o_data[k], memval(k, m_beat[k]));
                    check($sformatf("d%0d_tlast", k), 32'(o_last[k]), 32'(m_beat[k] == nw(k) - 1));
                end else begin
                    check($sformatf("d%0d_spurious_valid", k), 32'(o_valid[k]), 32'd0);
                end
            end
            if (o_rden[k]) begin
                check($sformatf("d%0d_rd_addr", k), 32'(o_addr[k]), 32'(m_next_addr[k]));
                check($sformatf("d%0d_rd_range", k), 32'(o_addr[k] < nw(k)), 32'd1);
                check($sformatf("d%0d_rd_when_busy", k), 32'(o_rden[k] && m_busy[k] != 0), 32'd1);
                check($sformatf("d%0d_rd_outstanding", k),
                      32'((m_next_addr[k] + 1 - m_beat[k] - int'(hs[k])) <= 2), 32'd1);
                if (o_addr[k] > lg_max_addr[k]) lg_max_addr[k] = o_addr[k];
            end
            if (hs[k]) begin
                if (lg_n[k] < 8) begin
                    lg_data[k][lg_n[k]] = o_data[k];
                    lg_last[k][lg_n[k]] = o_last[k];
                    lg_neg[k][lg_n[k]]  = neg_no;
                end
                lg_n[k]++;
            end
            if (o_done[k]) begin
                lg_done_n[k]++;
                lg_done_neg[k] = neg_no;
            end
            if (o_busy[k]) lg_busy_n[k]++;
            prev_stall[k] = (o_valid[k] && !o_ready[k]) ? 1 : 0;
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (m_done_due[k] != 0) begin
                m_done_due[k] = 0; m_busy[k] = 0; m_since[k] = -1;
            end
            if (o_rden[k]) m_next_addr[k]++;
            if (hs[k]) begin
                m_beat[k]++;
                if (m_beat[k] == nw(k)) m_done_due[k] = 1;
            end
            if (m_busy[k] != 0 && m_since[k] >= 0) m_since[k]++;
            if (acc[k]) begin
                m_busy[k] = 1; m_beat[k] = 0; m_next_addr[k] = 0; m_since[k] = 0;
                lg_start_neg[k] = neg_no;
            end
        end
        #1;
    endtask

    task automatic run_until_done(input int k, input int budget);
        int c;
        c = 0;
        while (lg_done_n[k] == 0 && c < budget) begin
            cyc();
            c++;
        end
        check($sformatf("d%0d_done_count", k), 32'(lg_done_n[k]), 32'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        sample();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_d%0d_tvalid", tag, k), 32'(o_valid[k]), 32'd0);
            check($sformatf("%s_d%0d_tdata", tag, k), o_data[k], 32'd0);
            check($sformatf("%s_d%0d_tlast", tag, k), 32'(o_last[k]), 32'd0);
            check($sformatf("%s_d%0d_busy", tag, k), 32'(o_busy[k]), 32'd0);
            check($sformatf("%s_d%0d_done", tag, k), 32'(o_done[k]), 32'd0);
            check($sformatf("%s_d%0d_rden", tag, k), 32'(o_rden[k]), 32'd0);
            check($sformatf("%s_d%0d_addr", tag, k), 32'(o_addr[k]), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int c;
        int nlast;
        rst_n = 1'b0;
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        ax0.tready = 1'b0; ax1.tready = 1'b0; ax2.tready = 1'b0;
        mem0[0] = 8'h0A; mem0[1] = 8'h1A;
        for (int i = 0; i < 8; i++) mem1[i] = 8'(i + 1);
        mem2[0] = 8'hFF;
        model_reset();
        for (int k = 0; k < 3; k++) clear_log(k);
        #22;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) cyc();

        // T1: back-to-back beats with the sink always ready
        clear_log(0);
        ax0.tready = 1'b1;
        start0 = 1'b1; cyc(); start0 = 1'b0;
        s = lg_start_neg[0];
        run_until_done(0, 20);
        repeat (2) cyc();
        check("t1_beats", 32'(lg_n[0]), 32'd2);
        check("t1_data0", lg_data[0][0], 32'h0000000A);
        check("t1_data1", lg_data[0][1], 32'h0000001A);
        check("t1_last0", 32'(lg_last[0][0]), 32'd0);
        check("t1_last1", 32'(lg_last[0][1]), 32'd1);
        check("t1_beat0_time", 32'(lg_neg[0][0]), 32'(s + 3));
        check("t1_beat1_time", 32'(lg_neg[0][1]), 32'(s + 4));
        check("t1_done_time", 32'(lg_done_neg[0]), 32'(s + 5));

        // T2: sink stalls for 5 cycles after TVALID rises
        clear_log(0);
        ax0.tready = 1'b0;
        start0 = 1'b1; cyc(); start0 = 1'b0;
        c = 0;
        while (!o_valid[0] && c < 10) begin cyc(); c++; end
        check("t2_valid_seen", 32'(o_valid[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t2_stall_data", o_data[0], 32'h0000000A);
            check("t2_stall_last", 32'(o_last[0]), 32'd0);
            check("t2_stall_rden", 32'(o_rden[0]), 32'd0);
        end
        ax0.tready = 1'b1;
        run_until_done(0, 20);
        check("t2_beats", 32'(lg_n[0]), 32'd2);
        check("t2_data0", lg_data[0][0], 32'h0000000A);
        check("t2_data1", lg_data[0][1], 32'h0000001A);
        repeat (2) cyc();

        // T3: START re-pulsed on cycles 1 and 3 of the packet
        clear_log(0);
        start0 = 1'b1; cyc();
        s = lg_start_neg[0];
        cyc(); start0 = 1'b0;
        cyc(); start0 = 1'b1;
        cyc(); start0 = 1'b0;
        run_until_done(0, 20);
        repeat (4) cyc();
        check("t3_beats", 32'(lg_n[0]), 32'd2);
        check("t3_done_pulses", 32'(lg_done_n[0]), 32'd1);
        check("t3_busy_cycles", 32'(lg_busy_n[0]), 32'(lg_done_neg[0] - s));

        // T4: asynchronous reset between beat 1 and beat 2
        clear_log(0);
        start0 = 1'b1; cyc(); start0 = 1'b0;
        c = 0;
        while (lg_n[0] == 0 && c < 20) begin cyc(); c++; end
        check("t4_first_beat", 32'(lg_n[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t4_async");
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        cyc();
        clear_log(0);
        start0 = 1'b1; cyc(); start0 = 1'b0;
        run_until_done(0, 20);
        check("t4_beats", 32'(lg_n[0]), 32'd2);
        check("t4_data0", lg_data[0][0], 32'h0000000A);
        check("t4_data1", lg_data[0][1], 32'h0000001A);
        repeat (2) cyc();

        // T5: eight-entry packet with a random sink
        clear_log(1);
        start1 = 1'b1; cyc(); start1 = 1'b0;
        c = 0;
        while (lg_done_n[1] == 0 && c < 300) begin
            ax1.tready = 1'($urandom_range(0, 1));
            cyc();
            c++;
        end
        ax1.tready = 1'b0;
        check("t5_done", 32'(lg_done_n[1]), 32'd1);
        check("t5_beats", 32'(lg_n[1]), 32'd8);
        nlast = 0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("t5_data%0d", i), lg_data[1][i], 32'(i + 1));
            if (lg_last[1][i]) nlast++;
        end
        check("t5_last_on_8", 32'(lg_last[1][7]), 32'd1);
        check("t5_last_count", 32'(nlast), 32'd1);
        check("t5_max_addr", 32'(lg_max_addr[1]), 32'd7);
        repeat (2) cyc();

        // T6: single-entry packet
        clear_log(2);
        ax2.tready = 1'b1;
        start2 = 1'b1; cyc(); start2 = 1'b0;
        run_until_done(2, 20);
        check("t6_beats", 32'(lg_n[2]), 32'd1);
        check("t6_data", lg_data[2][0], 32'h000000FF);
        check("t6_last", 32'(lg_last[2][0]), 32'd1);
        check("t6_done_time", 32'(lg_done_neg[2]), 32'(lg_neg[2][0] + 1));
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
